// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready on both sides.
// Non-MUL ops finish in one cycle. MUL runs WIDTH shift-add iterations.
// The result and all flags are registered.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]     OP_MUL   = 4'hA;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, ill_q, ill_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]   add_s, sub_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s, acc_step_s;
  logic             alu_carry_s, alu_ovf_s, alu_ill_s, accept_s;

  assign add_s      = {1'b0, a} + {1'b0, b};
  assign sub_s      = {1'b0, a} - {1'b0, b};
  assign shamt_s    = b[SHW-1:0];
  assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

  // Single-cycle datapath for every op except MUL.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_ill_s   = 1'b0;
    case (op)
      4'h0: begin
        alu_res_s   = add_s[WIDTH-1:0];
        alu_carry_s = add_s[WIDTH];
        alu_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'h1: begin
        alu_res_s   = sub_s[WIDTH-1:0];
        alu_carry_s = ~sub_s[WIDTH];  // no borrow means a >= b
        alu_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'h2: alu_res_s = a & b;
      4'h3: alu_res_s = a | b;
      4'h4: alu_res_s = a ^ b;
      4'h5: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      4'h6: alu_res_s = a << shamt_s;
      4'h7: alu_res_s = a >> shamt_s;
      4'h8: alu_res_s = $unsigned($signed(a) >>> shamt_s);
      4'h9: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'hA: alu_res_s = {WIDTH{1'b0}};  // MUL goes through the iterative path
      default: alu_ill_s = 1'b1;
    endcase
  end

  // Handshake, next-state and the MUL iteration step.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept_s = in_valid && in_ready;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s && (op == OP_MUL)) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = {SHW{1'b0}};
          state_d  = S_MUL;
        end else if (accept_s) begin
          result_d = alu_res_s;
          zero_d   = (alu_res_s == {WIDTH{1'b0}});
          neg_d    = alu_res_s[WIDTH-1];
          carry_d  = alu_carry_s;
          ovf_d    = alu_ovf_s;
          ill_d    = alu_ill_s;
          state_d  = S_DONE;
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_MUL: begin
        acc_d    = acc_step_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step_s;
          zero_d   = (acc_step_s == {WIDTH{1'b0}});
          neg_d    = acc_step_s[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  op = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, negative, carry, overflow, illegal;

  int tests = 0;
  int fails = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference: returns {illegal, overflow, carry, negative, zero, result[31:0]}
  function automatic logic [36:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint ux, uy, sx, sy, t;
    logic [63:0] w;
    logic [31:0] r;
    logic c, v, il;
    int sh;
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    sh = int'(y % 32);
    r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (o)
      4'h0: begin t = ux + uy; w = t; r = w[31:0]; c = (t > 64'sd4294967295);
                  t = sx + sy; v = (t > SMAX) || (t < SMIN); end
      4'h1: begin r = x - y; c = (ux >= uy);
                  t = sx - sy; v = (t > SMAX) || (t < SMIN); end
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = (ux < uy) ? 32'd1 : 32'd0;
      4'h6: r = x << sh;
      4'h7: r = x >> sh;
      4'h8: begin t = sx >>> sh; w = t; r = w[31:0]; end
      4'h9: r = (sx < sy) ? 32'd1 : 32'd0;
      4'hA: begin t = ux * uy; w = t; r = w[31:0]; end
      default: il = 1'b1;
    endcase
    return {il, v, c, r[31], (r == 32'd0), r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [36:0] e);
    check({tag, ".result"}, 64'(result), 64'(e[31:0]));
    check({tag, ".zero"}, 64'(zero), 64'(e[32]));
    check({tag, ".neg"}, 64'(negative), 64'(e[33]));
    check({tag, ".carry"}, 64'(carry), 64'(e[34]));
    check({tag, ".ovf"}, 64'(overflow), 64'(e[35]));
    check({tag, ".illegal"}, 64'(illegal), 64'(e[36]));
  endtask

  // Issue one op, wait (bounded) for out_valid, check latency and outputs.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic rdy);
    logic [36:0] e;
    int n;
    bit busy_ok;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = rdy;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = ref_alu(o, x, y);
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ok = 1'b0;
      a = $urandom; b = $urandom;  // operand changes must not matter
      @(posedge clk); #1;
      n++;
    end
    if (o == 4'hA) check({tag, ".busy_in_ready"}, 64'(busy_ok), 64'd1);
    check({tag, ".latency"}, 64'(n), (o == 4'hA) ? 64'd32 : 64'd0);
    check_outs(tag, e);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [36:0] e;
    logic [31:0] held;
    bit seen;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check_outs("rst", 37'd0);

    // Directed scenarios
    run_op("add_wrap", 4'h0, 32'hFFFFFFFF, 32'd1, 1'b1);
    check("add_wrap.expect", 64'({carry, zero, result}), 64'({1'b1, 1'b1, 32'd0}));
    run_op("sub_neg", 4'h1, 32'd3, 32'd5, 1'b1);
    check("sub_neg.expect", 64'(result), 64'hFFFFFFFE);
    run_op("sub_ovf", 4'h1, 32'h80000000, 32'd1, 1'b1);
    check("sub_ovf.expect", 64'({overflow, result}), 64'({1'b1, 32'h7FFFFFFF}));
    run_op("slt", 4'h9, 32'hFFFFFFFF, 32'd1, 1'b1);
    check("slt.expect", 64'(result), 64'd1);
    run_op("sltu", 4'h5, 32'hFFFFFFFF, 32'd1, 1'b1);
    check("sltu.expect", 64'(result), 64'd0);
    run_op("sra", 4'h8, 32'h80000000, 32'h24, 1'b1);
    check("sra.expect", 64'(result), 64'hF8000000);
    run_op("sll32", 4'h6, 32'h1234ABCD, 32'd32, 1'b1);
    run_op("mul", 4'hA, 32'h12345, 32'h10, 1'b1);
    check("mul.expect", 64'(result), 64'h123450);
    run_op("mul_b0", 4'hA, 32'hDEADBEEF, 32'd0, 1'b1);

    // Backpressure then back-to-back accept
    @(posedge clk);
    run_op("bp", 4'h0, 32'h11111111, 32'h22222222, 1'b0);
    held = result;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_result", 64'(result), 64'(held));
    end
    run_op("b2b", 4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1);

    // Reset during MUL iteration 10
    @(negedge clk);
    op = 4'hA; a = 32'd7; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mul.out_valid", 64'(out_valid), 64'd0);
    check("rst_mul.in_ready", 64'(in_ready), 64'd1);
    check("rst_mul.result", 64'(result), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_mul.no_pulse", 64'(seen), 64'd0);

    // Illegal op
    run_op("ill", 4'hC, 32'h55, 32'h66, 1'b1);
    check("ill.expect", 64'({illegal, zero, result}), 64'({1'b1, 1'b1, 32'd0}));

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      run_op($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
